char_buffer_writer: RTL

//  Writer side of the 16x16 text-mode character buffer. The buffer is read by the char renderer via

---
 rtl/char_buffer_writer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/char_buffer_writer.sv
// char_buffer_writer - byte-stream writer for the 16x16 text-mode character buffer
// Keeps a cursor, interprets control codes and drives the registered char RAM write port.
module char_buffer_writer #(
    parameter int          COLUMNS = 16,
    parameter int          ROWS    = 16,
    parameter logic [7:0]  BLANK   = 8'h20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       char_valid,
    input  logic [7:0] char_code,
    output logic       char_ready,
    input  logic       clear_req,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [3:0] cursor_col,
    output logic [3:0] cursor_row,
    output logic       busy
);

    typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_LINE} state_t;

    localparam logic [3:0] COL_LAST = 4'(COLUMNS - 1);
    localparam logic [3:0] ROW_LAST = 4'(ROWS - 1);

    state_t     state_q, state_d;
    logic       clear_pend;
    logic [3:0] cnt_col, cnt_row;
    logic       xfer, is_print;
    logic [3:0] row_next;

    logic       wr_en_d;
    logic [7:0] wr_addr_d, wr_data_d;
    logic [3:0] col_d, row_d, cnt_col_d, cnt_row_d;

    assign char_ready = (state_q == IDLE) && !clear_req && !clear_pend;
    assign xfer       = char_valid && char_ready;
    assign busy       = (state_q != IDLE);
    assign is_print   = (char_code >= 8'h20) && (char_code <= 8'h7E);
    assign row_next   = (cursor_row == ROW_LAST) ? 4'd0 : cursor_row + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= CLR_ALL;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CLR_ALL: begin
                if (cnt_col == COL_LAST && cnt_row == ROW_LAST) state_d = IDLE;
            end
            IDLE: begin
                if (clear_req || clear_pend) begin
                    state_d = CLR_ALL;
                end else if (xfer) begin
                    if (is_print && cursor_col == COL_LAST) state_d = CLR_LINE;
                    else if (char_code == 8'h0A)            state_d = CLR_LINE;
                    else if (char_code == 8'h0C)            state_d = CLR_ALL;
                end
            end
            CLR_LINE: begin
                if (cnt_col == COL_LAST) state_d = IDLE;
            end
            default: state_d = CLR_ALL;
        endcase
    end

    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr;
        wr_data_d = wr_data;
        col_d     = cursor_col;
        row_d     = cursor_row;
        cnt_col_d = cnt_col;
        cnt_row_d = cnt_row;
        case (state_q)
            CLR_ALL: begin
                wr_en_d   = 1'b1;
                wr_addr_d = {cnt_col, cnt_row};
                wr_data_d = BLANK;
                if (cnt_col == COL_LAST) begin
                    cnt_col_d = 4'd0;
                    if (cnt_row == ROW_LAST) begin
                        cnt_row_d = 4'd0;
                        col_d     = 4'd0;
                        row_d     = 4'd0;
                    end else begin
                        cnt_row_d = cnt_row + 4'd1;
                    end
                end else begin
                    cnt_col_d = cnt_col + 4'd1;
                end
            end
            IDLE: begin
                if (xfer) begin
                    if (is_print) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = {cursor_col, cursor_row};
                        wr_data_d = char_code;
                        if (cursor_col == COL_LAST) begin
                            col_d = 4'd0;
                            row_d = row_next;
                        end else begin
                            col_d = cursor_col + 4'd1;
                        end
                    end else if (char_code == 8'h0A) begin
                        col_d = 4'd0;
                        row_d = row_next;
                    end else if (char_code == 8'h0D) begin
                        col_d = 4'd0;
                    end else if (char_code == 8'h08 && cursor_col != 4'd0) begin
                        col_d     = cursor_col - 4'd1;
                        wr_en_d   = 1'b1;
                        wr_addr_d = {cursor_col - 4'd1, cursor_row};
                        wr_data_d = BLANK;
                    end
                end
            end
            CLR_LINE: begin
                // cursor_row already points at the freshly entered line
                wr_en_d   = 1'b1;
                wr_addr_d = {cnt_col, cursor_row};
                wr_data_d = BLANK;
                cnt_col_d = (cnt_col == COL_LAST) ? 4'd0 : cnt_col + 4'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en      <= 1'b0;
            wr_addr    <= 8'h00;
            wr_data    <= 8'h00;
            cursor_col <= 4'd0;
            cursor_row <= 4'd0;
            cnt_col    <= 4'd0;
            cnt_row    <= 4'd0;
            clear_pend <= 1'b0;
        end else begin
            wr_en      <= wr_en_d;
            wr_addr    <= wr_addr_d;
            wr_data    <= wr_data_d;
            cursor_col <= col_d;
            cursor_row <= row_d;
            cnt_col    <= cnt_col_d;
            cnt_row    <= cnt_row_d;
            // only a line clear can defer a request; a full clear absorbs it
            if (state_q == CLR_LINE && clear_req) clear_pend <= 1'b1;
            else if (state_q == IDLE)             clear_pend <= 1'b0;
        end
    end

endmodule
